// File: rtl/phase_seq_pkg.sv
// Shared definitions for the phase sequencer: state encoding and parameter defaults.
package phase_seq_pkg;

  localparam int DEF_COUNTER_BIT_COUNT = 16;
  localparam int DEF_NUM_PHASES        = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } seq_state_e;

endpackage

// File: rtl/phase_sequencer_count_core.sv
// Phase cycle counter: counts 0..terminal-1 while enabled and wraps to 0 after
// the terminal position. stop_count flags the last counted cycle.
module count_core
  import phase_seq_pkg::*;
#(
  parameter int W = DEF_COUNTER_BIT_COUNT
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         enable,
  input  logic         clear,
  input  logic [W-1:0] terminal,
  output logic [W-1:0] count,
  output logic         stop_count
);

  logic [W-1:0] r_count;
  logic [W-1:0] w_last_pos;

  // Last counted position of the phase; the caller never passes terminal = 0.
  always_comb begin
    w_last_pos = terminal - W'(1);
    stop_count = enable && (r_count == w_last_pos);
  end

  // Counter register: clear wins, then wrap at the terminal position, else step.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable) begin
      if (stop_count) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + W'(1);
      end
    end else begin
      r_count <= r_count;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/phase_sequencer.sv
// Programmable multi-phase sequencer. Phase lengths are captured at start, each
// phase counts its length in cycles, and the sequence runs once or loops.
// A pause request takes effect on the following edge, so the frozen interval
// lasts exactly as many cycles as pause was held high.
module phase_sequencer
  import phase_seq_pkg::*;
#(
  parameter int COUNTER_BIT_COUNT = DEF_COUNTER_BIT_COUNT,
  parameter int NUM_PHASES        = DEF_NUM_PHASES
) (
  input  logic                                  clk,
  input  logic                                  nrst,
  input  logic                                  start,
  input  logic                                  abort,
  input  logic                                  pause,
  input  logic                                  repeat_mode,
  input  logic [NUM_PHASES*COUNTER_BIT_COUNT-1:0] phase_len,
  output logic                                  busy,
  output logic [$clog2(NUM_PHASES)-1:0]         phase_idx,
  output logic [COUNTER_BIT_COUNT-1:0]          count,
  output logic                                  phase_tick,
  output logic                                  seq_done
);

  localparam int IDX_W = $clog2(NUM_PHASES);

  seq_state_e                   r_state;
  seq_state_e                   w_next_state;
  logic [COUNTER_BIT_COUNT-1:0] r_shadow [NUM_PHASES];
  logic [IDX_W-1:0]             r_phase_idx;
  logic [COUNTER_BIT_COUNT-1:0] w_len_raw;
  logic [COUNTER_BIT_COUNT-1:0] w_term;
  logic                         w_enable;
  logic                         w_clear;
  logic                         w_stop;
  logic                         w_last_phase;
  logic                         w_accept;

  // Active phase length, with a programmed 0 treated as a single cycle.
  always_comb begin
    w_len_raw    = r_shadow[r_phase_idx];
    w_term       = (w_len_raw == '0) ? COUNTER_BIT_COUNT'(1) : w_len_raw;
    w_last_phase = (r_phase_idx == IDX_W'(NUM_PHASES - 1));
    w_accept     = (r_state == ST_IDLE) && start && !abort;
    w_enable     = (r_state == ST_RUN) && !abort;
    w_clear      = (r_state == ST_IDLE) || abort;
  end

  count_core #(
    .W (COUNTER_BIT_COUNT)
  ) u_count_core (
    .clk        (clk),
    .nrst       (nrst),
    .enable     (w_enable),
    .clear      (w_clear),
    .terminal   (w_term),
    .count      (count),
    .stop_count (w_stop)
  );

  // Tick and completion pulses; both are suppressed by abort via w_enable.
  always_comb begin
    phase_tick = 1'b0;
    seq_done   = 1'b0;
    if (w_stop) begin
      phase_tick = 1'b1;
      seq_done   = w_last_phase && !repeat_mode;
    end else begin
      phase_tick = 1'b0;
      seq_done   = 1'b0;
    end
  end

  // Next-state logic: abort outranks completion, pause and start.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next_state = ST_RUN;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (abort || seq_done) begin
          w_next_state = ST_IDLE;
        end else if (pause) begin
          w_next_state = ST_HOLD;
        end else begin
          w_next_state = ST_RUN;
        end
      end
      ST_HOLD: begin
        if (abort) begin
          w_next_state = ST_IDLE;
        end else if (!pause) begin
          w_next_state = ST_RUN;
        end else begin
          w_next_state = ST_HOLD;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Shadow lengths are captured only when a sequence is accepted.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < NUM_PHASES; i++) begin
        r_shadow[i] <= '0;
      end
    end else if (w_accept) begin
      for (int i = 0; i < NUM_PHASES; i++) begin
        r_shadow[i] <= phase_len[i*COUNTER_BIT_COUNT +: COUNTER_BIT_COUNT];
      end
    end else begin
      r_shadow <= r_shadow;
    end
  end

  // Phase index: cleared when idle or aborted, advanced (with wrap) on each tick.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_phase_idx <= '0;
    end else if (w_clear) begin
      r_phase_idx <= '0;
    end else if (w_stop) begin
      if (w_last_phase) begin
        r_phase_idx <= '0;
      end else begin
        r_phase_idx <= r_phase_idx + IDX_W'(1);
      end
    end else begin
      r_phase_idx <= r_phase_idx;
    end
  end

  assign phase_idx = r_phase_idx;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_phase_sequencer.sv
// Self-checking bench for phase_sequencer. Expected tick events (cycle, phase,
// completion flag) are queued from the programmed lengths when a sequence is
// started and popped as the DUT produces ticks. Cycle k means the k-th cycle
// after the one in which start was presented.
module tb_phase_sequencer;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        pause = 1'b0;
  logic        repeat_mode = 1'b0;
  logic [63:0] phase_len = '0;
  logic        busy;
  logic [1:0]  phase_idx;
  logic [15:0] count;
  logic        phase_tick;
  logic        seq_done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int cyc;
    int idx;
    bit done;
  } tick_t;

  tick_t exp_q[$];

  phase_sequencer #(
    .COUNTER_BIT_COUNT (16),
    .NUM_PHASES        (4)
  ) dut (
    .clk         (clk),
    .nrst        (nrst),
    .start       (start),
    .abort       (abort),
    .pause       (pause),
    .repeat_mode (repeat_mode),
    .phase_len   (phase_len),
    .busy        (busy),
    .phase_idx   (phase_idx),
    .count       (count),
    .phase_tick  (phase_tick),
    .seq_done    (seq_done)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] pack_len(input int lens[4]);
    return {16'(lens[3]), 16'(lens[2]), 16'(lens[1]), 16'(lens[0])};
  endfunction

  // Queue expected ticks for the first nph phases starting after cycle t0;
  // phases at or beyond dly_ph are shifted by dly cycles.
  function automatic void push_seq(input int lens[4], input int t0, input int nph,
                                   input bit done_last, input int dly_ph, input int dly);
    int c;
    tick_t t;
    c = t0;
    for (int i = 0; i < nph; i++) begin
      c     = c + ((lens[i] == 0) ? 1 : lens[i]);
      t.cyc = c + ((i >= dly_ph) ? dly : 0);
      t.idx = i;
      t.done = done_last && (i == 3);
      exp_q.push_back(t);
    end
  endfunction

  task automatic do_start(input int lens[4], input bit rm);
    @(negedge clk);
    phase_len   = pack_len(lens);
    repeat_mode = rm;
    start       = 1'b1;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    #12;
    checks++;
    if (busy !== 1'b0 || phase_idx !== 2'd0 || count !== 16'd0 || phase_tick !== 1'b0 || seq_done !== 1'b0) begin
      errors++;
      $display("FAIL reset: busy=%b idx=%0d count=%0d tick=%b done=%b, required all zero", busy, phase_idx, count, phase_tick, seq_done);
    end
    @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic test_oneshot();
    int lens[4] = '{3, 1, 2, 4};
    tick_t e;
    do_start(lens, 1'b0);
    push_seq(lens, 0, 4, 1'b1, 4, 0);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (phase_tick === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL oneshot_tick: unexpected tick at cycle %0d idx %0d", k, phase_idx);
        end else begin
          e = exp_q.pop_front();
          if (k != e.cyc || phase_idx !== 2'(e.idx) || seq_done !== e.done) begin
            errors++;
            $display("FAIL oneshot_tick: cycle %0d idx %0d done %b, required cycle %0d idx %0d done %b", k, phase_idx, seq_done, e.cyc, e.idx, e.done);
          end
        end
      end else if (seq_done !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL oneshot_done: seq_done=1 without tick at cycle %0d, required 0", k);
      end
      if (k == 1) begin
        checks++;
        if (busy !== 1'b1 || count !== 16'd0 || phase_idx !== 2'd0) begin
          errors++;
          $display("FAIL oneshot_first: busy=%b count=%0d idx=%0d, required 1/0/0", busy, count, phase_idx);
        end
      end
      if (k == 11) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL oneshot_idle: busy=%b at cycle 11, required 0", busy);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL oneshot_missing: %0d ticks not seen, required 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_repeat_abort();
    int lens[4] = '{3, 1, 2, 4};
    tick_t e;
    do_start(lens, 1'b1);
    push_seq(lens, 0, 4, 1'b0, 4, 0);
    push_seq(lens, 10, 2, 1'b0, 4, 0);
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      start = 1'b0;
      abort = (k == 16);
      #1;
      if (k == 16) begin
        checks++;
        if (phase_idx !== 2'd2 || count !== 16'd1 || phase_tick !== 1'b0 || seq_done !== 1'b0) begin
          errors++;
          $display("FAIL abort_cycle: idx=%0d count=%0d tick=%b done=%b, required 2/1/0/0", phase_idx, count, phase_tick, seq_done);
        end
      end
      if (phase_tick === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL repeat_tick: unexpected tick at cycle %0d idx %0d", k, phase_idx);
        end else begin
          e = exp_q.pop_front();
          if (k != e.cyc || phase_idx !== 2'(e.idx) || seq_done !== e.done) begin
            errors++;
            $display("FAIL repeat_tick: cycle %0d idx %0d done %b, required cycle %0d idx %0d done %b", k, phase_idx, seq_done, e.cyc, e.idx, e.done);
          end
        end
      end else if (seq_done !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL repeat_done: seq_done=1 without tick at cycle %0d, required 0", k);
      end
      if (k == 11) begin
        checks++;
        if (busy !== 1'b1 || phase_idx !== 2'd0 || count !== 16'd0) begin
          errors++;
          $display("FAIL repeat_wrap: busy=%b idx=%0d count=%0d, required 1/0/0", busy, phase_idx, count);
        end
      end
      if (k == 17) begin
        checks++;
        if (busy !== 1'b0 || phase_idx !== 2'd0 || count !== 16'd0) begin
          errors++;
          $display("FAIL abort_idle: busy=%b idx=%0d count=%0d, required 0/0/0", busy, phase_idx, count);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL repeat_missing: %0d ticks not seen, required 0", exp_q.size());
    end
    exp_q.delete();
    abort = 1'b0;
    repeat_mode = 1'b0;
  endtask

  task automatic test_pause();
    int lens[4] = '{2, 3, 2, 2};
    tick_t e;
    do_start(lens, 1'b0);
    push_seq(lens, 0, 4, 1'b1, 1, 5);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      start = 1'b0;
      pause = (k >= 2 && k <= 6);
      #1;
      if (phase_tick === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pause_tick: unexpected tick at cycle %0d idx %0d", k, phase_idx);
        end else begin
          e = exp_q.pop_front();
          if (k != e.cyc || phase_idx !== 2'(e.idx) || seq_done !== e.done) begin
            errors++;
            $display("FAIL pause_tick: cycle %0d idx %0d done %b, required cycle %0d idx %0d done %b", k, phase_idx, seq_done, e.cyc, e.idx, e.done);
          end
        end
      end
      if (k >= 3 && k <= 7) begin
        checks++;
        if (busy !== 1'b1 || phase_idx !== 2'd1 || count !== 16'd0 || phase_tick !== 1'b0) begin
          errors++;
          $display("FAIL pause_hold: cycle %0d busy=%b idx=%0d count=%0d tick=%b, required 1/1/0/0", k, busy, phase_idx, count, phase_tick);
        end
      end
      if (k == 16) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL pause_idle: busy=%b, required 0", busy);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pause_missing: %0d ticks not seen, required 0", exp_q.size());
    end
    exp_q.delete();
    pause = 1'b0;
  endtask

  task automatic test_len_bounds();
    int lens_z[4] = '{1, 1, 0, 1};
    int lens_m[4] = '{65535, 1, 1, 1};
    tick_t e;
    do_start(lens_z, 1'b0);
    push_seq(lens_z, 0, 4, 1'b1, 4, 0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (phase_tick === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL zero_tick: unexpected tick at cycle %0d idx %0d", k, phase_idx);
        end else begin
          e = exp_q.pop_front();
          if (k != e.cyc || phase_idx !== 2'(e.idx) || seq_done !== e.done || count !== 16'd0) begin
            errors++;
            $display("FAIL zero_tick: cycle %0d idx %0d done %b count %0d, required cycle %0d idx %0d done %b count 0", k, phase_idx, seq_done, count, e.cyc, e.idx, e.done);
          end
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL zero_missing: %0d ticks not seen, required 0", exp_q.size());
    end
    exp_q.delete();

    do_start(lens_m, 1'b0);
    push_seq(lens_m, 0, 4, 1'b1, 4, 0);
    for (int k = 1; k <= 65540; k++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (phase_tick === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL max_tick: unexpected tick at cycle %0d idx %0d", k, phase_idx);
        end else begin
          e = exp_q.pop_front();
          if (k != e.cyc || phase_idx !== 2'(e.idx) || seq_done !== e.done) begin
            errors++;
            $display("FAIL max_tick: cycle %0d idx %0d done %b, required cycle %0d idx %0d done %b", k, phase_idx, seq_done, e.cyc, e.idx, e.done);
          end
        end
      end
      if (k == 65535) begin
        checks++;
        if (count !== 16'hFFFE || phase_tick !== 1'b1) begin
          errors++;
          $display("FAIL max_count: count=%h tick=%b, required fffe/1", count, phase_tick);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL max_missing: %0d ticks not seen, required 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_start_rules();
    int lens[4]  = '{3, 1, 2, 4};
    int lens2[4] = '{1, 1, 1, 1};
    tick_t e;
    @(negedge clk);
    phase_len = pack_len(lens);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || count !== 16'd0) begin
      errors++;
      $display("FAIL start_abort: busy=%b count=%0d, required 0/0", busy, count);
    end

    do_start(lens, 1'b0);
    push_seq(lens, 0, 4, 1'b1, 4, 0);
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      start = (k == 2);
      if (k == 2) begin
        phase_len = pack_len(lens2);
      end
      #1;
      if (phase_tick === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL busy_tick: unexpected tick at cycle %0d idx %0d", k, phase_idx);
        end else begin
          e = exp_q.pop_front();
          if (k != e.cyc || phase_idx !== 2'(e.idx) || seq_done !== e.done) begin
            errors++;
            $display("FAIL busy_tick: cycle %0d idx %0d done %b, required cycle %0d idx %0d done %b", k, phase_idx, seq_done, e.cyc, e.idx, e.done);
          end
        end
      end
      if (k == 12) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL busy_restart: busy=%b after one-shot end, required 0", busy);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL busy_missing: %0d ticks not seen, required 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    int lens[4]  = '{3, 1, 2, 4};
    int lens2[4] = '{2, 2, 2, 2};
    tick_t e;
    do_start(lens, 1'b0);
    push_seq(lens, 0, 3, 1'b0, 4, 0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (phase_tick === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rst_tick: unexpected tick at cycle %0d idx %0d", k, phase_idx);
        end else begin
          e = exp_q.pop_front();
          if (k != e.cyc || phase_idx !== 2'(e.idx)) begin
            errors++;
            $display("FAIL rst_tick: cycle %0d idx %0d, required cycle %0d idx %0d", k, phase_idx, e.cyc, e.idx);
          end
        end
      end
    end
    nrst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || phase_idx !== 2'd0 || count !== 16'd0 || phase_tick !== 1'b0 || seq_done !== 1'b0) begin
      errors++;
      $display("FAIL rst_async: busy=%b idx=%0d count=%0d tick=%b done=%b, required all zero", busy, phase_idx, count, phase_tick, seq_done);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rst_missing: %0d ticks not seen, required 0", exp_q.size());
    end
    exp_q.delete();
    @(negedge clk);
    nrst = 1'b1;

    do_start(lens2, 1'b0);
    push_seq(lens2, 0, 4, 1'b1, 4, 0);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (k == 1) begin
        checks++;
        if (busy !== 1'b1 || phase_idx !== 2'd0 || count !== 16'd0) begin
          errors++;
          $display("FAIL rst_restart: busy=%b idx=%0d count=%0d, required 1/0/0", busy, phase_idx, count);
        end
      end
      if (phase_tick === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rst_new_tick: unexpected tick at cycle %0d idx %0d", k, phase_idx);
        end else begin
          e = exp_q.pop_front();
          if (k != e.cyc || phase_idx !== 2'(e.idx) || seq_done !== e.done) begin
            errors++;
            $display("FAIL rst_new_tick: cycle %0d idx %0d done %b, required cycle %0d idx %0d done %b", k, phase_idx, seq_done, e.cyc, e.idx, e.done);
          end
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rst_new_missing: %0d ticks not seen, required 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_repeat_abort();
    test_pause();
    test_start_rules();
    test_reset_mid();
    test_len_bounds();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/phase_sequencer.md
PHASE_SEQUENCER -- requirements
Module: phase_sequencer

Interface
REQ-001 SHALL have parameter COUNTER_BIT_COUNT, default 16, width of the phase counter and of each phase length.
REQ-002 SHALL have parameter NUM_PHASES, default 4, number of programmable phases (2..16).
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port nrst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  single-cycle request to begin a sequence.
REQ-006 SHALL have port abort  input  1  single-cycle request to terminate a sequence immediately.
REQ-007 SHALL have port pause  input  1  level; while high, counting freezes.
REQ-008 SHALL have port repeat_mode  input  1  level; 1 = loop the sequence, 0 = one-shot.
REQ-009 SHALL have port phase_len  input  NUM_PHASES*COUNTER_BIT_COUNT  packed lengths; phase i occupies bits [i*W +: W].
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.
REQ-011 SHALL have port phase_idx  output  clog2(NUM_PHASES)  index of the active phase.
REQ-012 SHALL have port count  output  COUNTER_BIT_COUNT  cycle position within the active phase.
REQ-013 SHALL have port phase_tick  output  1  pulse on the last counted cycle of each phase.
REQ-014 SHALL have port seq_done  output  1  pulse marking completion of a one-shot sequence.

Function
REQ-015 SHALL implement the FSM states IDLE, RUN, HOLD.
REQ-016 SHALL, on start=1 in IDLE with abort=0, capture phase_len into shadow registers and enter RUN next cycle with count=0 and phase_idx=0.
REQ-017 SHALL ignore start when not in IDLE; later phase_len changes SHALL NOT affect the running sequence.
REQ-018 SHALL, in RUN, increment count by 1 per cycle from 0 up to L-1, where L = the shadow length of the active phase.
REQ-019 SHALL treat a shadow length of 0 as 1 cycle.
REQ-020 SHALL assert phase_tick combinationally in the RUN cycle where count==L-1, then clear count to 0 and advance phase_idx on the next edge.
REQ-021 SHALL, at the tick of phase NUM_PHASES-1, wrap phase_idx to 0 and stay in RUN if repeat_mode=1 in that cycle.
REQ-022 SHALL, at that tick with repeat_mode=0, assert seq_done in the same cycle as phase_tick, then enter IDLE with count=0 and phase_idx=0.
REQ-023 SHALL go RUN->HOLD when pause=1 and HOLD->RUN when pause=0; in HOLD, count and phase_idx hold and phase_tick=0.
REQ-024 SHALL, on abort=1 in RUN or HOLD, enter IDLE next cycle with count=0 and phase_idx=0, without asserting phase_tick or seq_done in that cycle.
REQ-025 SHALL give abort priority over pause, start and a coincident terminal count.
REQ-026 SHALL make count wrap arithmetic modulo 2^COUNTER_BIT_COUNT impossible: maximum L is 2^W-1, so count never exceeds L-1.

Reset
REQ-027 SHALL, on nrst=0, asynchronously force: state=IDLE, count=0, phase_idx=0, busy=0, phase_tick=0, seq_done=0, and shadow lengths=0.
REQ-028 SHALL, on reset mid-sequence, discard all progress; the first post-reset start SHALL begin at phase 0.

Structure
REQ-029 SHALL take its state enumeration and parameter defaults from the shared package phase_seq_pkg.
REQ-030 SHALL instantiate one sub-module, count_core, containing the counter register.
REQ-031 SHALL give count_core the inputs enable, clear and terminal value, and the outputs count and stop_count (enable && count==terminal-1).
REQ-032 SHALL place the FSM, the shadow registers and phase_idx in phase_sequencer.

Verification
REQ-033 SHALL cover: lengths {3,1,2,4}, repeat_mode=0, start -> ticks at cycles 3,4,6,10 after start; seq_done with the last tick; busy low at cycle 11.
REQ-034 SHALL cover: same lengths, repeat_mode=1 -> phase_idx wraps 3->0 with no seq_done; abort at phase 2 count 1 -> IDLE next cycle, no tick.
REQ-035 SHALL cover: pause high for 5 cycles at phase 1 count 0 of lengths {2,3,2,2} -> count frozen; phase 1 tick delayed by exactly 5 cycles.
REQ-036 SHALL cover: a length of 0 in phase 2 -> that phase lasts 1 cycle; a length of 0xFFFF -> tick at count=0xFFFE.
REQ-037 SHALL cover: start with abort in the same IDLE cycle -> stays IDLE; start while busy -> ignored; phase_len changed mid-run -> timing unchanged.
REQ-038 SHALL cover: nrst pulsed low mid-phase -> all outputs zero asynchronously; a new start runs from phase 0.
